// File: rtl/nd_nto1_pkg.sv
// Shared defaults, output-side state encoding and width helper for the nd_nto1 merge node.
package nd_nto1_pkg;

  localparam int unsigned NS_ADDRESS_SIZE = 4;
  localparam int unsigned NS_DATA_SIZE    = 8;
  localparam int unsigned NS_REDUN_SIZE   = 4;
  localparam int unsigned NS_2TO1_FSZ     = 4;
  localparam int unsigned NS_REQ_CKS      = 1;
  localparam int unsigned NS_ACK_CKS      = 1;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic [1:0] {
    SND_IDLE = 2'd0,
    SND_REQ  = 2'd1,
    SND_REL  = 2'd2
  } snd_state_t;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nd_rr_arb.sv
// One-of-NCH grant selector; round-robin from ptr+1, or fixed lowest-index priority
// when NS_ND_NTO1_FIXED_PRIO_EN is defined.
module nd_rr_arb
  import nd_nto1_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [NCH-1:0] pending,
  input  logic           en,
  output logic [NCH-1:0] gnt_c,
  output logic           gnt_vld_c
);

`ifdef NS_ND_NTO1_FIXED_PRIO_EN
  // Scan high to low so the lowest pending index is written last and wins.
  always_comb begin
    gnt_c     = '0;
    gnt_vld_c = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en && pending[i]) begin
        gnt_c     = '0;
        gnt_c[i]  = 1'b1;
        gnt_vld_c = 1'b1;
      end
    end
  end
`else
  localparam int unsigned PW = idx_w(NCH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;

  // First pending channel after the last winner, wrapping modulo NCH.
  always_comb begin
    gnt_c     = '0;
    gnt_vld_c = 1'b0;
    idx       = '0;
    win       = ptr;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = PW'((32'(ptr) + k) % NCH);
      if (!gnt_vld_c && en && pending[idx]) begin
        gnt_c[idx] = 1'b1;
        gnt_vld_c  = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= PW'(NCH - 1);
    end else if (gnt_vld_c) begin
      ptr <= win;
    end
  end
`endif

endmodule

// File: rtl/nd_nto1.sv
// N-to-1 four-phase merge node: debounced inputs, arbitration, shared FIFO, single output.
// Build option NS_ND_NTO1_FIXED_PRIO_EN selects fixed lowest-index priority arbitration.
module nd_nto1
  import nd_nto1_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned FSZ         = NS_2TO1_FSZ,
  parameter int unsigned ASZ         = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ         = NS_DATA_SIZE,
  parameter int unsigned RSZ         = NS_REDUN_SIZE,
  parameter int unsigned RCV_REQ_CKS = NS_REQ_CKS,
  parameter int unsigned SND_ACK_CKS = NS_ACK_CKS
) (
  input  logic               gch_clk,
  input  logic               gch_reset,
  output logic               gch_ready,
  input  logic [NCH-1:0]     rcv_req,
  output logic [NCH-1:0]     rcv_ack_out,
  input  logic [NCH*ASZ-1:0] rcv_src,
  input  logic [NCH*ASZ-1:0] rcv_dst,
  input  logic [NCH*DSZ-1:0] rcv_dat,
  input  logic [NCH*RSZ-1:0] rcv_red,
  output logic               snd0_req_out,
  input  logic               snd0_ack,
  output logic [ASZ-1:0]     snd0_src,
  output logic [ASZ-1:0]     snd0_dst,
  output logic [DSZ-1:0]     snd0_dat,
  output logic [RSZ-1:0]     snd0_red
);

  localparam int unsigned MSZ = 2 * ASZ + DSZ + RSZ;
  localparam int unsigned AW  = idx_w(FSZ);
  localparam int unsigned CW  = idx_w(FSZ + 1);
  localparam int unsigned RW  = idx_w(RCV_REQ_CKS);
  localparam int unsigned KW  = idx_w(SND_ACK_CKS);

  logic             rg_rdy;
  logic             clr;
  logic [NCH-1:0]   ckd_req;
  logic             ckd_ack;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   gnt;
  logic             gnt_vld;
  logic [MSZ-1:0]   msg_c;
  logic [MSZ-1:0]   mem [FSZ];
  logic [MSZ-1:0]   rd_msg;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [KW-1:0]    ack_cnt;
  snd_state_t       st;

  // Init runs while reset is high and once more on the first edge after it drops.
  assign clr       = gch_reset | ~rg_rdy;
  assign gch_ready = rg_rdy;

  always_ff @(posedge gch_clk) begin
    if (gch_reset) rg_rdy <= 1'b0;
    else           rg_rdy <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_req_db
    logic          ckd;
    logic [RW-1:0] cnt;
    always_ff @(posedge gch_clk) begin
      if (clr) begin
        ckd <= 1'b0;
        cnt <= '0;
      end else if (rcv_req[i] == ckd) begin
        cnt <= '0;
      end else if (cnt == RW'(RCV_REQ_CKS - 1)) begin
        ckd <= rcv_req[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + RW'(1);
      end
    end
    assign ckd_req[i] = ckd;
  end

  always_ff @(posedge gch_clk) begin
    if (clr) begin
      ckd_ack <= 1'b0;
      ack_cnt <= '0;
    end else if (snd0_ack == ckd_ack) begin
      ack_cnt <= '0;
    end else if (ack_cnt == KW'(SND_ACK_CKS - 1)) begin
      ckd_ack <= snd0_ack;
      ack_cnt <= '0;
    end else begin
      ack_cnt <= ack_cnt + KW'(1);
    end
  end

  assign pending = ckd_req & ~rcv_ack_out;
  assign full    = (count == CW'(FSZ));
  assign empty   = (count == '0);

  nd_rr_arb #(.NCH(NCH)) u_arb (
    .clk       (gch_clk),
    .clr       (clr),
    .pending   (pending),
    .en        (~full),
    .gnt_c     (gnt),
    .gnt_vld_c (gnt_vld)
  );

  // Winning channel's fields packed as {src, dst, dat, red}.
  always_comb begin
    msg_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        msg_c = {rcv_src[i*ASZ +: ASZ], rcv_dst[i*ASZ +: ASZ],
                 rcv_dat[i*DSZ +: DSZ], rcv_red[i*RSZ +: RSZ]};
      end
    end
  end

  assign push   = gnt_vld & ~clr;
  assign pop    = (st == SND_IDLE) & ~empty;
  assign rd_msg = mem[rd_ptr];

  always_ff @(posedge gch_clk) begin
    if (push) mem[wr_ptr] <= msg_c;
  end

  always_ff @(posedge gch_clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Ack is held until the debounced request falls.
  always_ff @(posedge gch_clk) begin
    if (clr) begin
      rcv_ack_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (gnt[i])           rcv_ack_out[i] <= 1'b1;
        else if (!ckd_req[i]) rcv_ack_out[i] <= 1'b0;
      end
    end
  end

  // Output four-phase handshake; fields hold until the next load.
  always_ff @(posedge gch_clk) begin
    if (clr) begin
      st           <= SND_IDLE;
      snd0_req_out <= 1'b0;
      snd0_src     <= '0;
      snd0_dst     <= '0;
      snd0_dat     <= '0;
      snd0_red     <= '0;
    end else begin
      case (st)
        SND_IDLE: begin
          if (!empty) begin
            {snd0_src, snd0_dst, snd0_dat, snd0_red} <= rd_msg;
            snd0_req_out <= 1'b1;
            st           <= SND_REQ;
          end
        end
        SND_REQ: begin
          if (ckd_ack) begin
            snd0_req_out <= 1'b0;
            st           <= SND_REL;
          end
        end
        SND_REL: begin
          if (!ckd_ack) st <= SND_IDLE;
        end
        default: st <= SND_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nd_nto1.sv
// Directed bench for nd_nto1 (NCH=4, FSZ=4, debounce of one cycle).
module tb_nd_nto1;

  localparam int unsigned NCH = 4;
  localparam int unsigned FSZ = 4;
  localparam int unsigned ASZ = 4;
  localparam int unsigned DSZ = 8;
  localparam int unsigned RSZ = 4;

  logic               clk = 1'b0;
  logic               gch_reset;
  logic               gch_ready;
  logic [NCH-1:0]     rcv_req;
  logic [NCH-1:0]     rcv_ack_out;
  logic [NCH*ASZ-1:0] rcv_src;
  logic [NCH*ASZ-1:0] rcv_dst;
  logic [NCH*DSZ-1:0] rcv_dat;
  logic [NCH*RSZ-1:0] rcv_red;
  logic               snd0_req_out;
  logic               snd0_ack;
  logic [ASZ-1:0]     snd0_src;
  logic [ASZ-1:0]     snd0_dst;
  logic [DSZ-1:0]     snd0_dat;
  logic [RSZ-1:0]     snd0_red;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nd_nto1 #(
    .NCH(NCH), .FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .RCV_REQ_CKS(1), .SND_ACK_CKS(1)
  ) dut (
    .gch_clk      (clk),
    .gch_reset    (gch_reset),
    .gch_ready    (gch_ready),
    .rcv_req      (rcv_req),
    .rcv_ack_out  (rcv_ack_out),
    .rcv_src      (rcv_src),
    .rcv_dst      (rcv_dst),
    .rcv_dat      (rcv_dat),
    .rcv_red      (rcv_red),
    .snd0_req_out (snd0_req_out),
    .snd0_ack     (snd0_ack),
    .snd0_src     (snd0_src),
    .snd0_dst     (snd0_dst),
    .snd0_dat     (snd0_dat),
    .snd0_red     (snd0_red)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic [DSZ-1:0] d);
    rcv_src[i*ASZ +: ASZ] = ASZ'(i);
    rcv_dst[i*ASZ +: ASZ] = ASZ'(NCH - 1 - i);
    rcv_dat[i*DSZ +: DSZ] = d;
    rcv_red[i*RSZ +: RSZ] = RSZ'(i + 8);
  endtask

  task automatic do_reset();
    gch_reset = 1'b1;
    rcv_req   = '0;
    snd0_ack  = 1'b0;
    step(2);
    gch_reset = 1'b0;
    step(1);
  endtask

  task automatic wait_out(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (snd0_req_out === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    gch_reset = 1'b1;
    rcv_req = '0; snd0_ack = 1'b0;
    rcv_src = '0; rcv_dst = '0; rcv_dat = '0; rcv_red = '0;
    step(3);
    checks++; if (gch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", gch_ready); end
    gch_reset = 1'b0;
    step(1);
    checks++; if (gch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", gch_ready); end
    checks++; if (snd0_req_out !== 1'b0) begin errors++; $display("FAIL reset_req_out: got %b expected 0", snd0_req_out); end
    checks++; if (rcv_ack_out !== 4'b0000) begin errors++; $display("FAIL reset_acks: got %b expected 0000", rcv_ack_out); end
  endtask

  task automatic test_single();
    bit ok;
    set_ch(2, 8'h5A);
    rcv_req[2] = 1'b1;
    step(2);
    checks++; if (rcv_ack_out !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", rcv_ack_out); end
    checks++; if (snd0_req_out !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", snd0_req_out); end
    step(1);
    checks++; if (snd0_req_out !== 1'b1) begin errors++; $display("FAIL single_req_out: got %b expected 1", snd0_req_out); end
    checks++; if (snd0_dat !== 8'h5A) begin errors++; $display("FAIL single_dat: got %h expected 5a", snd0_dat); end
    checks++; if ({snd0_src, snd0_dst, snd0_red} !== {4'd2, 4'd1, 4'd10}) begin errors++; $display("FAIL single_fields: got %h expected 21a", {snd0_src, snd0_dst, snd0_red}); end
    snd0_ack = 1'b1;
    wait_out(1'b0, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_req_drop: got %b expected 0", snd0_req_out); end
    snd0_ack = 1'b0;
    rcv_req[2] = 1'b0;
    step(3);
    checks++; if (rcv_ack_out !== 4'b0000) begin errors++; $display("FAIL single_ack_drop: got %b expected 0000", rcv_ack_out); end
    checks++; if (snd0_req_out !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", snd0_req_out); end
  endtask

  task automatic test_round_robin();
    int got[$];
    int seq[NCH];
    do_reset();
    for (int i = 0; i < NCH; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 600 && got.size() < 12; cyc++) begin
      @(negedge clk);
      if (snd0_req_out && !snd0_ack) begin
        got.push_back(int'(snd0_src));
        snd0_ack = 1'b1;
      end else if (!snd0_req_out && snd0_ack) begin
        snd0_ack = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (rcv_ack_out[i] && rcv_req[i]) begin
          rcv_req[i] = 1'b0;
        end else if (!rcv_ack_out[i] && !rcv_req[i]) begin
          set_ch(i, DSZ'(i * 16 + seq[i]));
          seq[i]++;
          rcv_req[i] = 1'b1;
        end
      end
    end
    checks++; if (got.size() != 12) begin errors++; $display("FAIL rr_count: got %0d expected 12", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] != k % NCH) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got[k], k % NCH); end
    end
    rcv_req = '0;
  endtask

  task automatic test_stall();
    int got[$];
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, DSZ'(8'h10 + i));
    rcv_req = 4'b1111;
    step(12);
    checks++; if (rcv_ack_out !== 4'b1111) begin errors++; $display("FAIL stall_first4: got %b expected 1111", rcv_ack_out); end
    checks++; if ({snd0_req_out, snd0_dat} !== {1'b1, 8'h10}) begin errors++; $display("FAIL stall_head: got %h expected 110", {snd0_req_out, snd0_dat}); end
    rcv_req[1:0] = 2'b00;
    step(4);
    checks++; if (rcv_ack_out !== 4'b1100) begin errors++; $display("FAIL stall_release: got %b expected 1100", rcv_ack_out); end
    set_ch(0, 8'h14);
    set_ch(1, 8'h15);
    rcv_req[1:0] = 2'b11;
    step(6);
    checks++; if (rcv_ack_out !== 4'b1101) begin errors++; $display("FAIL stall_full: got %b expected 1101", rcv_ack_out); end
    step(10);
    checks++; if (rcv_ack_out !== 4'b1101) begin errors++; $display("FAIL stall_hold: got %b expected 1101", rcv_ack_out); end
    for (int cyc = 0; cyc < 300 && got.size() < 6; cyc++) begin
      @(negedge clk);
      if (snd0_req_out && !snd0_ack) begin
        got.push_back(int'(snd0_dat));
        snd0_ack = 1'b1;
      end else if (!snd0_req_out && snd0_ack) begin
        snd0_ack = 1'b0;
      end
      for (int i = 0; i < NCH; i++) if (rcv_ack_out[i] && rcv_req[i]) rcv_req[i] = 1'b0;
    end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL stall_count: got %0d expected 6", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] != 16 + k) begin errors++; $display("FAIL stall_order[%0d]: got %h expected %h", k, got[k], 16 + k); end
    end
    rcv_req = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) set_ch(i, DSZ'(8'h20 + i));
    rcv_req = 4'b0111;
    step(8);
    checks++; if ({snd0_req_out, rcv_ack_out} !== 5'b1_0111) begin errors++; $display("FAIL mid_pre: got %b expected 10111", {snd0_req_out, rcv_ack_out}); end
    gch_reset = 1'b1;
    rcv_req = '0;
    step(1);
    checks++; if ({gch_ready, snd0_req_out, rcv_ack_out} !== 6'b0) begin errors++; $display("FAIL mid_abort: got %b expected 000000", {gch_ready, snd0_req_out, rcv_ack_out}); end
    gch_reset = 1'b0;
    step(1);
    checks++; if (gch_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", gch_ready); end
    step(6);
    checks++; if (snd0_req_out !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: got %b expected 0", snd0_req_out); end
    set_ch(3, 8'h77);
    rcv_req[3] = 1'b1;
    wait_out(1'b1, 10, ok);
    checks++; if (!ok || snd0_dat !== 8'h77) begin errors++; $display("FAIL mid_new_msg: got %b/%h expected 1/77", snd0_req_out, snd0_dat); end
    snd0_ack = 1'b1;
    rcv_req[3] = 1'b0;
    wait_out(1'b0, 5, ok);
    snd0_ack = 1'b0;
    step(6);
    checks++; if ({ok, snd0_req_out} !== 2'b10) begin errors++; $display("FAIL mid_no_stale: got %b expected 10", {ok, snd0_req_out}); end
  endtask

  task automatic test_contested();
    logic [NCH-1:0] exp_ack;
    do_reset();
    set_ch(1, 8'h31);
    set_ch(3, 8'h33);
    rcv_req[1] = 1'b1;
    step(4);
    checks++; if (rcv_ack_out !== 4'b0010) begin errors++; $display("FAIL cont_first: got %b expected 0010", rcv_ack_out); end
    rcv_req[1] = 1'b0;
    step(4);
    checks++; if (rcv_ack_out !== 4'b0000) begin errors++; $display("FAIL cont_release: got %b expected 0000", rcv_ack_out); end
    rcv_req = 4'b1010;
    step(2);
`ifdef NS_ND_NTO1_FIXED_PRIO_EN
    exp_ack = 4'b0010;
`else
    exp_ack = 4'b1000;
`endif
    checks++; if (rcv_ack_out !== exp_ack) begin errors++; $display("FAIL cont_winner: got %b expected %b", rcv_ack_out, exp_ack); end
    rcv_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_contested();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nd_nto1.md
Name: nd_nto1

Overview:
- N-input, 1-output merge node for the message network.
- Accepts four-phase req/ack messages on NCH input channels and arbitrates between them round-robin.
- Queues accepted messages in one shared FSZ-deep FIFO and re-issues them, in order, on a single four-phase output channel.
- Parametrised successor of the fixed 2-input merge node. Used wherever several producers feed one consumer.

Parameters:
- NCH, 4, number of input channels (>=2).
- FSZ, `NS_2to1_FSZ, FIFO depth in messages (power of two, >=2).
- ASZ, `NS_ADDRESS_SIZE, width of the src and dst fields.
- DSZ, `NS_DATA_SIZE, width of the data field.
- RSZ, `NS_REDUN_SIZE, width of the redundancy field.
- RCV_REQ_CKS, `NS_REQ_CKS, number of stable cycles required to debounce an input req.
- SND_ACK_CKS, `NS_ACK_CKS, number of stable cycles required to debounce the output ack.

Ports:
- gch_clk  in  1  clock.
- gch_reset  in  1  synchronous reset, active-high.
- gch_ready  out  1  node initialised.
- rcv_req  in  NCH  per-channel request.
- rcv_ack_out  out  NCH  per-channel acknowledge.
- rcv_src, rcv_dst  in  NCH*ASZ each  packed; channel i occupies [i*ASZ +: ASZ].
- rcv_dat  in  NCH*DSZ  packed.
- rcv_red  in  NCH*RSZ  packed.
- snd0_req_out  out  1  output request.
- snd0_ack  in  1  output acknowledge.
- snd0_src, snd0_dst  out  ASZ each  output message address fields.
- snd0_dat  out  DSZ  output message data.
- snd0_red  out  RSZ  output message redundancy.

Behaviour:
- Reset and init:
  - While gch_reset is high, rg_rdy is 0.
  - On the first edge with reset low, init runs: all outputs, message registers, acks and FIFO pointers clear to 0; arbitration pointer set to NCH-1, so channel 0 is favoured first; debouncers clear. rg_rdy is set to 1.
  - gch_ready = rg_rdy. Reset asserted mid-transfer aborts everything, and init runs again after reset drops.
- Debounce:
  - ckd_req[i] rises after rcv_req[i] has been high for RCV_REQ_CKS consecutive cycles, and falls after it has been low for RCV_REQ_CKS consecutive cycles.
  - ckd_ack is the same function of snd0_ack, using SND_ACK_CKS.
- Pending: channel i is pending when ckd_req[i] && !rcv_ack_out[i].
- Arbitration:
  - Each cycle, at most one pending channel is granted. The search starts at ptr+1 and wraps modulo NCH.
  - A grant happens only if the FIFO is not full.
  - On a grant to channel g at edge t: the message is written at the FIFO head, rcv_ack_out[g] is 1 from t+1, and ptr<=g.
  - With no grant, ptr is unchanged.
  - FIFO full: no grant and no ack; the pending request waits without loss.
- Ack release: rcv_ack_out[i] goes to 0 on the first edge where !ckd_req[i]. Channel i cannot be granted again until that has happened.
- Output side:
  - When the output is not busy and the FIFO is not empty: load the tail message into the snd0_* fields, set snd0_req_out=1 and busy=1, and pop.
  - When ckd_ack=1 with req high: snd0_req_out<=0.
  - When ckd_ack=0 with req low and busy: busy<=0.
  - The snd0_* fields hold their value until the next load.
- Simultaneous events:
  - A push and a pop in the same cycle are both performed and the count is unchanged.
  - A push into a full FIFO is not possible, even when a pop happens in the same cycle, because fullness is evaluated pre-edge.
  - Pointers wrap modulo FSZ.
- Ordering and latency:
  - The FIFO preserves grant order.
  - Minimum latency, from ckd_req high to snd0_req_out high with an empty FIFO and an idle output, is 2 edges.

Optional Feature:
- Macro NS_ND_NTO1_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest-index pending channel always wins and the ptr register is removed.
- Undefined: round-robin as described above.

Decomposition:
- Shared content goes in hglobal.v: the ASZ/DSZ/RSZ defaults, NS_ON/NS_OFF, the message-field macros and the FIFO macro family.
- One sub-module, nd_rr_arb (parameter NCH), is natural:
  - Inputs: pending vector and an enable (FIFO not full).
  - Outputs: one-hot grant and a grant-valid flag.
  - Holds the ptr register internally.
- Debouncers use the existing debouncer macros, instanced per channel inside a generate loop.

Test Plan:
- Reset release → gch_ready=0 during reset, 1 on the edge after release; snd0_req_out=0 and all rcv_ack_out=0.
- Single message on ch2 (dat=0x5A) with NCH=4 and CKS=1 → rcv_ack_out[2] rises; snd0_dat=0x5A with snd0_req_out=1 two edges after ckd_req; req drops after snd0_ack, and ack drops after rcv_req[2] drops.
- All 4 channels requesting continuously, each re-requesting after its ack, with snd0 acked promptly → output src order 0,1,2,3,0,1,… with no channel granted twice before all others.
- Output stalled (snd0_ack held 0), FSZ=4, 6 requests → 1 message in the output register plus 4 in the FIFO are acked; the remaining 1 stays un-acked until snd0 completes, then is accepted with no loss or reorder.
- gch_reset asserted while snd0_req_out=1 and the FIFO holds 2 messages → on the next edge snd0_req_out=0 and the FIFO is empty; after release the node re-initialises and accepts new traffic normally.
- Build with NS_ND_NTO1_FIXED_PRIO_EN, channels 1 and 3 requesting repeatedly → channel 1 wins every contested cycle.
